step_counter: RTL and testbench
===============================

# step_counter

Parametrised stepping counter, the next-generation successor to the single-shot step counter. Latches a step size, direction and limit on `start`, then adds or subtracts the step every clock until the limit is reached, `stop` is asserted, or arithmetic overflow ends the run. Width, step size and overflow policy are configurable. It sits beside the homework datapath blocks as a reusable sequencer and counter.

## Interface
- `STEP_W`, default 4: width of the step input.
- `COUNT_W`, default 8: width of the count, limit and arithmetic (`COUNT_W` ≥ `STEP_W`).

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a new run (or restart); latches `step`, `dir` and `limit`.
- `stop`  in  1: abort the run; count holds.
- `step`  in  `STEP_W`: increment/decrement amount, sampled only on `start`.
- `dir`  in  1: 0 = count up, 1 = count down; sampled on `start`.
- `limit`  in  `COUNT_W`: terminal value for up runs, start value for down runs; sampled on `start`.
- `count`  out  `COUNT_W`: current count.
- `overflow`  out  1: sticky carry/borrow flag.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse on terminal count.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset forces IDLE, `count` = 0, `overflow` = 0, `busy` = 0, `done` = 0, and clears the latched `step_q`, `dir_q` and `lim_q`.
- Priority, highest first: `rst`, then `start`, then `stop`, then the RUN update.
- `start` in any state:
  - Latch `step_q`, `dir_q` and `lim_q`.
  - Load `count` with 0 if up, or with `limit` if down.
  - Clear `overflow` and go to RUN.
  - `start` during RUN is a restart.
- `stop` in RUN goes to IDLE with `count` held and `overflow` held. `stop` in IDLE or DONE is ignored.
- RUN update: compute `nxt` = `count` ± `step_q` at `COUNT_W`+1 bits.
  - Up, no carry, and `nxt` ≥ `lim_q`: `count` = `nxt`, pulse `done`, go to DONE.
  - Down, no borrow, and `nxt` == 0: `count` = 0, pulse `done`, go to DONE.
  - Carry (up) or borrow (down): set `overflow`; the result then follows the Configuration policy. No terminal check is made on that cycle.
  - Otherwise: `count` = `nxt[COUNT_W-1:0]`.
- `step_q` = 0: the count never changes. Exceptions: an up run with `lim_q` = 0 terminates on its first RUN cycle, and a down run with `lim_q` = 0 also terminates on its first RUN cycle.
- DONE holds `count` and `overflow`, with `busy` = 0, until `start` or `rst`.
- `busy` = 1 exactly when the state is RUN.

## Timing
- Edge N samples `start`=1: after edge N, `count` holds its initial value and `busy` = 1.
- Edge N+1: first update, `count` = initial ± step.
- `done` is registered and asserts in the same cycle `count` first shows the terminal value. It is high for exactly one cycle, and `busy` drops in that same cycle.
- `overflow` asserts in the same cycle as the wrapped or saturated `count`.
- `rst` mid-run takes effect at the next edge and overrides a simultaneous `start`.
- `start` and `stop` together: `start` wins, giving a restart.

## Configuration
- `STEP_COUNTER_SAT_EN` defined: on carry, `count` = all ones; on borrow, `count` = 0. In both cases `overflow` = 1, `done` pulses and the FSM goes to DONE.
- Macro undefined: on carry or borrow, `count` = `nxt` modulo 2^`COUNT_W`, `overflow` = 1, and the FSM stays in RUN with no `done` pulse.

## Test plan
- Up run with defaults: `start` with `step`=4, `dir`=0, `limit`=20 → `count` sequence 0, 4, 8, 12, 16, 20. `done` pulses at 20, `busy` falls with it, `overflow`=0, and `count` holds at 20.
- Down run: `step`=3, `dir`=1, `limit`=9 → sequence 9, 6, 3, 0, then `done`. Repeat with `limit`=10 → sequence 10, 7, 4, 1, then a borrow on the next cycle, which follows the overflow policy.
- Overflow: `step`=10, `dir`=0, `limit`=255 → sequence …, 240, 250.
  - With `SAT_EN`: next `count`=255, `overflow`=1, one `done` pulse.
  - Without: next `count`=4, `overflow`=1, `busy` stays 1, no `done`; then `stop` → IDLE with 14 or the current value held.
- Stop and restart: `step`=1, `limit`=100; `stop` at `count`=5 → `count` holds 5 and `busy`=0. Then `start` with `step`=2 → sequence 0, 2, 4, ….
- Reset mid-run: `rst` asserted at `count`=7 together with `start` → next cycle `count`=0, IDLE, all outputs 0.
- Zero step: `step`=0, `limit`=0, up → `done` on the first RUN cycle with `count`=0. With `limit`=5, `count` stays at 0 with `busy`=1 until `stop`.

Source files
------------

// File: rtl/step_counter.sv
// Stepping counter: latches step/dir/limit on start, then steps count toward the limit each clock.
// Define STEP_COUNTER_SAT_EN to saturate and finish on carry/borrow; otherwise the count wraps and the run continues.
module step_counter #(
    parameter int unsigned STEP_W  = 4,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [STEP_W-1:0]  step,
    input  logic               dir,
    input  logic [COUNT_W-1:0] limit,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    output logic               busy,
    output logic               done
);

    localparam int unsigned EXT_W = COUNT_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               dir_q, dir_d;
    logic [COUNT_W-1:0] lim_q, lim_d;
    logic [COUNT_W-1:0] count_d;
    logic               overflow_d, busy_d, done_d;
    logic [EXT_W-1:0]   nxt;
    logic               wrap;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            step_q   <= '0;
            dir_q    <= 1'b0;
            lim_q    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            lim_q    <= lim_d;
            count    <= count_d;
            overflow <= overflow_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Next state: start beats stop, stop beats the RUN update
    always_comb begin
        state_d    = state;
        step_d     = step_q;
        dir_d      = dir_q;
        lim_d      = lim_q;
        count_d    = count;
        overflow_d = overflow;
        done_d     = 1'b0;
        // Extra top bit of nxt is the carry (up) or borrow (down)
        nxt        = dir_q ? ({1'b0, count} - EXT_W'(step_q))
                           : ({1'b0, count} + EXT_W'(step_q));
        wrap       = nxt[COUNT_W];

        if (start) begin
            step_d     = step;
            dir_d      = dir;
            lim_d      = limit;
            count_d    = dir ? limit : '0;
            overflow_d = 1'b0;
            state_d    = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (wrap) begin
                        overflow_d = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                        count_d = dir_q ? '0 : '1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
`else
                        count_d = nxt[COUNT_W-1:0];
`endif
                    end else if ((!dir_q && (nxt >= {1'b0, lim_q})) ||
                                 (dir_q && (nxt == '0))) begin
                        count_d = nxt[COUNT_W-1:0];
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        count_d = nxt[COUNT_W-1:0];
                    end
                end
                ST_IDLE, ST_DONE: state_d = state;
                default:          state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_RUN);
    end

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter: directed scenarios plus randomized traffic against an integer model.
module tb_step_counter;

    localparam int unsigned STEP_W  = 4;
    localparam int unsigned COUNT_W = 8;
    localparam int CMAX = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst, start, stop, dir;
    logic [STEP_W-1:0]  step;
    logic [COUNT_W-1:0] limit;
    logic [COUNT_W-1:0] count;
    logic               overflow, busy, done;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0 idle, 1 running, 2 finished
    int m_mode, m_cnt, m_step, m_dir, m_lim;
    bit m_ovf, m_done;

    always #5 clk = ~clk;

    step_counter #(.STEP_W(STEP_W), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .dir(dir),
        .limit(limit), .count(count), .overflow(overflow), .busy(busy), .done(done)
    );

    task automatic model_update();
        int n;
        m_done = 0;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_ovf = 0; m_step = 0; m_dir = 0; m_lim = 0;
        end else if (start) begin
            m_step = int'(step); m_dir = int'(dir); m_lim = int'(limit);
            m_cnt = dir ? int'(limit) : 0;
            m_ovf = 0;
            m_mode = 1;
        end else if (m_mode == 1 && stop) begin
            m_mode = 0;
        end else if (m_mode == 1) begin
            n = (m_dir == 0) ? m_cnt + m_step : m_cnt - m_step;
            if (n > CMAX || n < 0) begin
                m_ovf = 1;
`ifdef STEP_COUNTER_SAT_EN
                m_cnt = (n > CMAX) ? CMAX : 0;
                m_done = 1;
                m_mode = 2;
`else
                m_cnt = (n > CMAX) ? n - (CMAX + 1) : n + (CMAX + 1);
`endif
            end else if ((m_dir == 0 && n >= m_lim) || (m_dir == 1 && n == 0)) begin
                m_cnt = n; m_done = 1; m_mode = 2;
            end else begin
                m_cnt = n;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; stop = 1'b0; step = 4'd5; dir = 1'b0; limit = 8'd50;
        tick();
        rst = 1'b0; start = 1'b0;
        checks++;
        if ({count, overflow, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: count=%0d ovf=%b busy=%b done=%b, expected all zero",
                     count, overflow, busy, done);
        end
    endtask

    task automatic test_up_run();
        logic [COUNT_W-1:0] e_cnt;
        logic e_busy, e_done;
        start = 1'b1; step = 4'd4; dir = 1'b0; limit = 8'd20;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 6; i++) begin
            e_cnt  = COUNT_W'((i > 5) ? 20 : 4 * i);
            e_done = (i == 5);
            e_busy = (i < 5);
            checks++;
            if ({count, overflow, busy, done} !== {e_cnt, 1'b0, e_busy, e_done}) begin
                errors++;
                $display("FAIL up_run[%0d]: count=%0d ovf=%b busy=%b done=%b, expected count=%0d ovf=0 busy=%b done=%b",
                         i, count, overflow, busy, done, e_cnt, e_busy, e_done);
            end
            tick();
        end
    endtask

    task automatic test_down_run();
        logic [COUNT_W-1:0] e_cnt;
        logic e_ovf, e_busy, e_done;
        start = 1'b1; step = 4'd3; dir = 1'b1; limit = 8'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            e_cnt = COUNT_W'(9 - 3 * i); e_done = (i == 3); e_busy = (i < 3);
            checks++;
            if ({count, overflow, busy, done} !== {e_cnt, 1'b0, e_busy, e_done}) begin
                errors++;
                $display("FAIL down_run9[%0d]: count=%0d ovf=%b busy=%b done=%b, expected count=%0d ovf=0 busy=%b done=%b",
                         i, count, overflow, busy, done, e_cnt, e_busy, e_done);
            end
            tick();
        end
        start = 1'b1; limit = 8'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            e_cnt = COUNT_W'(10 - 3 * i); e_ovf = 1'b0; e_busy = 1'b1; e_done = 1'b0;
            if (i == 4) begin
                e_ovf = 1'b1;
`ifdef STEP_COUNTER_SAT_EN
                e_cnt = 8'd0; e_busy = 1'b0; e_done = 1'b1;
`else
                e_cnt = 8'd254;
`endif
            end
            checks++;
            if ({count, overflow, busy, done} !== {e_cnt, e_ovf, e_busy, e_done}) begin
                errors++;
                $display("FAIL down_run10[%0d]: count=%0d ovf=%b busy=%b done=%b, expected count=%0d ovf=%b busy=%b done=%b",
                         i, count, overflow, busy, done, e_cnt, e_ovf, e_busy, e_done);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        logic [COUNT_W-1:0] e_cnt;
        logic e_busy, e_done;
        start = 1'b1; step = 4'd10; dir = 1'b0; limit = 8'd255;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 25; i++) tick();
        checks++;
        if ({count, overflow, busy} !== {8'd250, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ovf_pre: count=%0d ovf=%b busy=%b, expected count=250 ovf=0 busy=1",
                     count, overflow, busy);
        end
        tick();
`ifdef STEP_COUNTER_SAT_EN
        e_cnt = 8'd255; e_busy = 1'b0; e_done = 1'b1;
`else
        e_cnt = 8'd4; e_busy = 1'b1; e_done = 1'b0;
`endif
        checks++;
        if ({count, overflow, busy, done} !== {e_cnt, 1'b1, e_busy, e_done}) begin
            errors++;
            $display("FAIL ovf_edge: count=%0d ovf=%b busy=%b done=%b, expected count=%0d ovf=1 busy=%b done=%b",
                     count, overflow, busy, done, e_cnt, e_busy, e_done);
        end
`ifndef STEP_COUNTER_SAT_EN
        tick();
        e_cnt = 8'd14;
`endif
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({count, overflow, busy, done} !== {e_cnt, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ovf_stop: count=%0d ovf=%b busy=%b done=%b, expected count=%0d ovf=1 busy=0 done=0",
                     count, overflow, busy, done, e_cnt);
        end
    endtask

    task automatic test_stop_restart();
        start = 1'b1; step = 4'd1; dir = 1'b0; limit = 8'd100;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        checks++;
        if ({count, overflow, busy, done} !== {8'd5, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL stop_hold: count=%0d ovf=%b busy=%b done=%b, expected count=5 ovf=0 busy=0 done=0",
                     count, overflow, busy, done);
        end
        start = 1'b1; stop = 1'b1; step = 4'd2;
        tick();
        start = 1'b0; stop = 1'b0;
        for (int i = 0; i <= 3; i++) begin
            checks++;
            if ({count, busy, done} !== {COUNT_W'(2 * i), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL restart[%0d]: count=%0d busy=%b done=%b, expected count=%0d busy=1 done=0",
                         i, count, busy, done, 2 * i);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; step = 4'd1; dir = 1'b0; limit = 8'd100;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 7; i++) tick();
        checks++;
        if (count !== 8'd7) begin
            errors++;
            $display("FAIL rst_pre: count=%0d, expected 7", count);
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        tick();
        checks++;
        if ({count, overflow, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid: count=%0d ovf=%b busy=%b done=%b, expected all zero",
                     count, overflow, busy, done);
        end
    endtask

    task automatic test_zero_step();
        start = 1'b1; step = 4'd0; dir = 1'b0; limit = 8'd0;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({count, busy, done} !== {8'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL zero_lim0: count=%0d busy=%b done=%b, expected count=0 busy=0 done=1",
                     count, busy, done);
        end
        start = 1'b1; limit = 8'd5;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if ({count, busy, done} !== {8'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL zero_lim5: count=%0d busy=%b done=%b, expected count=0 busy=1 done=0",
                     count, busy, done);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        checks++;
        if ({count, busy, done} !== {8'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL zero_stop: count=%0d busy=%b done=%b, expected count=0 busy=0 done=0",
                     count, busy, done);
        end
    endtask

    task automatic test_random();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 800; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 11) == 0);
            step  = STEP_W'($urandom_range(0, (1 << STEP_W) - 1));
            dir   = 1'($urandom_range(0, 1));
            limit = COUNT_W'($urandom_range(0, CMAX));
            tick();
            checks++;
            if ({count, overflow, busy, done} !==
                {COUNT_W'(m_cnt), m_ovf, (m_mode == 1), m_done}) begin
                errors++;
                $display("FAIL random[%0d]: count=%0d ovf=%b busy=%b done=%b, expected count=%0d ovf=%b busy=%b done=%b",
                         i, count, overflow, busy, done, m_cnt, m_ovf, (m_mode == 1), m_done);
            end
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        m_mode = 0; m_cnt = 0; m_step = 0; m_dir = 0; m_lim = 0; m_ovf = 0; m_done = 0;
        test_reset();
        test_up_run();
        test_down_run();
        test_overflow();
        test_stop_restart();
        test_reset_mid_run();
        test_zero_step();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
